// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: data-hazard bubble insertion, branch flushing
// and a fixed-length memory-access stall sequence with a saturating stall counter.
module pipeline_hazard_ctrl #(
    parameter int unsigned MEM_WAIT_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  src_1,
    input  logic [3:0]  src_2,
    input  logic        two_src,
    input  logic [3:0]  exe_dest,
    input  logic        exe_wb_en,
    input  logic        exe_mem_r_en,
    input  logic [3:0]  mem_dest,
    input  logic        mem_wb_en,
    input  logic        mem_req,
    input  logic        branch_taken,
    input  logic        fwd_en,
    output logic        freeze_if,
    output logic        flush_if,
    output logic        flush_id,
    output logic        stall_all,
    output logic        mem_done,
    output logic [15:0] stall_cnt
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_MEM_DONE = 2'd2
    } state_e;

    // The RUN cycle already counts as the first stall cycle, so the wait
    // counter covers the remaining MEM_WAIT_CYCLES-1 cycles down to zero.
    localparam int unsigned WAIT_LOAD_INT = (MEM_WAIT_CYCLES > 1) ? (MEM_WAIT_CYCLES - 2) : 0;
    localparam logic [3:0]  WAIT_LOAD     = WAIT_LOAD_INT[3:0];
    localparam logic        SINGLE_CYCLE  = (MEM_WAIT_CYCLES == 1) ? 1'b1 : 1'b0;

    state_e      state_q, state_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic        src1_exe_s, src2_exe_s, src1_mem_s, src2_mem_s;
    logic        load_use_s, no_fwd_s, hazard_s;

    // Register-number comparisons and hazard classification
    always_comb begin
        src1_exe_s = (src_1 == exe_dest);
        src2_exe_s = two_src && (src_2 == exe_dest);
        src1_mem_s = (src_1 == mem_dest);
        src2_mem_s = two_src && (src_2 == mem_dest);
        load_use_s = exe_wb_en && exe_mem_r_en && (src1_exe_s || src2_exe_s);
        no_fwd_s   = (exe_wb_en && (src1_exe_s || src2_exe_s)) ||
                     (mem_wb_en && (src1_mem_s || src2_mem_s));
        if (fwd_en) begin
            hazard_s = load_use_s;
        end else begin
            hazard_s = no_fwd_s;
        end
    end

    // Next-state logic and combinational control outputs
    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        stall_all = 1'b0;
        mem_done  = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (mem_req) begin
                    stall_all = 1'b1;
                    if (SINGLE_CYCLE) begin
                        state_d = ST_MEM_DONE;
                    end else begin
                        state_d = ST_MEM_WAIT;
                        wcnt_d  = WAIT_LOAD;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_MEM_WAIT: begin
                stall_all = 1'b1;
                if (wcnt_q == 4'd0) begin
                    state_d = ST_MEM_DONE;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            ST_MEM_DONE: begin
                mem_done = 1'b1;
                state_d  = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
                wcnt_d  = 4'd0;
            end
        endcase

        // A full stall masks everything; a taken branch beats a hazard.
        freeze_if = 1'b0;
        flush_if  = 1'b0;
        flush_id  = 1'b0;
        if (stall_all) begin
            freeze_if = 1'b0;
        end else if (branch_taken) begin
            flush_if = 1'b1;
            flush_id = 1'b1;
        end else if (hazard_s) begin
            freeze_if = 1'b1;
            flush_id  = 1'b1;
        end else begin
            freeze_if = 1'b0;
        end
    end

    // Saturating count of cycles in which any part of the pipe is held
    always_comb begin
        if ((stall_all || freeze_if) && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State, wait counter and stall counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            wcnt_q      <= 4'd0;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two instances (4-cycle and 1-cycle memory
// stall) checked every cycle against a remaining-stall-cycles model.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  src_1, src_2, exe_dest, mem_dest;
    logic        two_src, exe_wb_en, exe_mem_r_en, mem_wb_en;
    logic        mem_req, branch_taken, fwd_en;

    logic        freeze_if_w [2];
    logic        flush_if_w  [2];
    logic        flush_id_w  [2];
    logic        stall_all_w [2];
    logic        mem_done_w  [2];
    logic [15:0] stall_cnt_w [2];

    int total = 0;
    int bad   = 0;

    int mwc        [2] = '{4, 1};
    int stall_left [2];
    bit in_done    [2];
    int cnt        [2];

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MEM_WAIT_CYCLES(4)) dut_a (
        .clk(clk), .rst(rst), .src_1(src_1), .src_2(src_2), .two_src(two_src),
        .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .mem_req(mem_req),
        .branch_taken(branch_taken), .fwd_en(fwd_en),
        .freeze_if(freeze_if_w[0]), .flush_if(flush_if_w[0]), .flush_id(flush_id_w[0]),
        .stall_all(stall_all_w[0]), .mem_done(mem_done_w[0]), .stall_cnt(stall_cnt_w[0])
    );

    pipeline_hazard_ctrl #(.MEM_WAIT_CYCLES(1)) dut_b (
        .clk(clk), .rst(rst), .src_1(src_1), .src_2(src_2), .two_src(two_src),
        .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .mem_req(mem_req),
        .branch_taken(branch_taken), .fwd_en(fwd_en),
        .freeze_if(freeze_if_w[1]), .flush_if(flush_if_w[1]), .flush_id(flush_id_w[1]),
        .stall_all(stall_all_w[1]), .mem_done(mem_done_w[1]), .stall_cnt(stall_cnt_w[1])
    );

    function automatic bit reads(input logic [3:0] r);
        return (src_1 == r) || (two_src && (src_2 == r));
    endfunction

    function automatic bit hazard();
        if (fwd_en) return exe_wb_en && exe_mem_r_en && reads(exe_dest);
        return (exe_wb_en && reads(exe_dest)) || (mem_wb_en && reads(mem_dest));
    endfunction

    task automatic model_out(input int i, output bit stall, output bit done,
                             output bit fif, output bit fid, output bit frz);
        done  = in_done[i];
        stall = !in_done[i] && ((stall_left[i] > 0) || (mem_req === 1'b1));
        fif = 1'b0; fid = 1'b0; frz = 1'b0;
        if (!stall && branch_taken) begin
            fif = 1'b1; fid = 1'b1;
        end else if (!stall && hazard()) begin
            frz = 1'b1; fid = 1'b1;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            stall_left[i] = 0; in_done[i] = 1'b0; cnt[i] = 0;
        end
    endtask

    task automatic model_update();
        bit s, d, fi, fd, fz;
        if (!rst) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 2; i++) begin
            model_out(i, s, d, fi, fd, fz);
            if ((s || fz) && cnt[i] < 65535) cnt[i]++;
            if (in_done[i]) begin
                in_done[i] = 1'b0;
            end else if (stall_left[i] > 0) begin
                stall_left[i]--;
                if (stall_left[i] == 0) in_done[i] = 1'b1;
            end else if (mem_req) begin
                stall_left[i] = mwc[i] - 1;
                if (stall_left[i] == 0) in_done[i] = 1'b1;
            end
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        bit s, d, fi, fd, fz;
        for (int i = 0; i < 2; i++) begin
            model_out(i, s, d, fi, fd, fz);
            chk1($sformatf("stall_all[%0d]", i), stall_all_w[i], s);
            chk1($sformatf("mem_done[%0d]", i),  mem_done_w[i],  d);
            chk1($sformatf("flush_if[%0d]", i),  flush_if_w[i],  fi);
            chk1($sformatf("flush_id[%0d]", i),  flush_id_w[i],  fd);
            chk1($sformatf("freeze_if[%0d]", i), freeze_if_w[i], fz);
            chk16($sformatf("stall_cnt[%0d]", i), stall_cnt_w[i], 16'(cnt[i]));
        end
    endtask

    task automatic settle();
        #1;
        compare_all();
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic set_rst(input logic v);
        rst = v;
        if (!v) model_reset();
    endtask

    task automatic quiet();
        src_1 = 4'd0; src_2 = 4'd0; two_src = 1'b0; exe_dest = 4'd0; mem_dest = 4'd0;
        exe_wb_en = 1'b0; exe_mem_r_en = 1'b0; mem_wb_en = 1'b0;
        mem_req = 1'b0; branch_taken = 1'b0; fwd_en = 1'b1;
    endtask

    initial begin
        quiet();
        set_rst(1'b0);
        @(negedge clk);
        settle();
        chk16("reset_cnt", stall_cnt_w[0], 16'd0);
        chk1("reset_stall", stall_all_w[0], 1'b0);
        advance();
        set_rst(1'b1);

        // 4-cycle access (A) and 1-cycle access (B) from the same request
        mem_req = 1'b1;
        settle();
        chk1("acc_c0_stall_a", stall_all_w[0], 1'b1);
        chk1("acc_c0_stall_b", stall_all_w[1], 1'b1);
        advance();
        mem_req = 1'b0;
        settle();
        chk1("acc_c1_stall_a", stall_all_w[0], 1'b1);
        chk1("acc_c1_done_b", mem_done_w[1], 1'b1);
        chk1("acc_c1_stall_b", stall_all_w[1], 1'b0);
        advance();
        settle(); chk1("acc_c2_stall_a", stall_all_w[0], 1'b1); advance();
        settle(); chk1("acc_c3_stall_a", stall_all_w[0], 1'b1); advance();
        settle();
        chk1("acc_c4_stall_a", stall_all_w[0], 1'b0);
        chk1("acc_c4_done_a", mem_done_w[0], 1'b1);
        advance();
        settle();
        chk1("acc_c5_done_a", mem_done_w[0], 1'b0);
        chk16("acc_cnt_a", stall_cnt_w[0], 16'd4);
        chk16("acc_cnt_b", stall_cnt_w[1], 16'd1);
        advance();

        // Load-use hazard with forwarding
        exe_mem_r_en = 1'b1; exe_wb_en = 1'b1; exe_dest = 4'd3; src_1 = 4'd3;
        settle();
        chk1("lu_freeze", freeze_if_w[0], 1'b1);
        chk1("lu_flush_id", flush_id_w[0], 1'b1);
        chk1("lu_flush_if", flush_if_w[0], 1'b0);
        advance();
        src_1 = 4'd4;
        settle();
        chk1("lu_off_freeze", freeze_if_w[0], 1'b0);
        chk1("lu_off_flush_id", flush_id_w[0], 1'b0);
        advance();
        src_1 = 4'd3; branch_taken = 1'b1;
        settle();
        chk1("br_hz_flush_if", flush_if_w[0], 1'b1);
        chk1("br_hz_flush_id", flush_id_w[0], 1'b1);
        chk1("br_hz_freeze", freeze_if_w[0], 1'b0);
        advance();

        // No-forward hazard on src_2 against MEM stage
        quiet();
        fwd_en = 1'b0; mem_wb_en = 1'b1; mem_dest = 4'd7; two_src = 1'b1; src_2 = 4'd7;
        settle(); chk1("nf_two_src_freeze", freeze_if_w[0], 1'b1); advance();
        two_src = 1'b0;
        settle(); chk1("nf_one_src_freeze", freeze_if_w[0], 1'b0); advance();

        // Branch during the wait is masked, honoured in MEM_DONE
        quiet();
        mem_req = 1'b1; settle(); advance();
        mem_req = 1'b0; branch_taken = 1'b1;
        settle();
        chk1("mw_br_stall", stall_all_w[0], 1'b1);
        chk1("mw_br_flush_if", flush_if_w[0], 1'b0);
        chk1("mw_br_flush_id", flush_id_w[0], 1'b0);
        advance();
        settle(); advance();
        settle(); advance();
        settle();
        chk1("md_br_done", mem_done_w[0], 1'b1);
        chk1("md_br_flush_if", flush_if_w[0], 1'b1);
        chk1("md_br_flush_id", flush_id_w[0], 1'b1);
        advance();

        // Reset in the second MEM_WAIT cycle aborts the access
        quiet();
        mem_req = 1'b1; settle(); advance();
        mem_req = 1'b0; settle(); advance();
        settle();
        chk1("rw_pre_stall", stall_all_w[0], 1'b1);
        #2;
        set_rst(1'b0);
        #1;
        chk1("rw_stall_drop", stall_all_w[0], 1'b0);
        chk16("rw_cnt_clear", stall_cnt_w[0], 16'd0);
        compare_all();
        advance();
        set_rst(1'b1);
        for (int k = 0; k < 5; k++) begin
            settle();
            chk1("rw_no_done", mem_done_w[0], 1'b0);
            advance();
        end

        // Randomised traffic, small register space for frequent matches
        for (int n = 0; n < 3000; n++) begin
            src_1 = 4'($urandom_range(0, 3)); src_2 = 4'($urandom_range(0, 3));
            exe_dest = 4'($urandom_range(0, 3)); mem_dest = 4'($urandom_range(0, 3));
            two_src = 1'($urandom); exe_wb_en = 1'($urandom); exe_mem_r_en = 1'($urandom);
            mem_wb_en = 1'($urandom); fwd_en = 1'($urandom);
            branch_taken = ($urandom_range(0, 3) == 0);
            mem_req = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 199) == 0) begin
                mem_req = 1'b0;
                set_rst(1'b0);
            end else begin
                set_rst(1'b1);
            end
            settle();
            advance();
        end

        // Hold a load-use hazard long enough to saturate the counter
        quiet();
        set_rst(1'b1);
        exe_mem_r_en = 1'b1; exe_wb_en = 1'b1; exe_dest = 4'd5; src_1 = 4'd5;
        for (int n = 0; n < 66000; n++) begin
            settle();
            advance();
        end
        settle();
        chk16("sat_cnt_a", stall_cnt_w[0], 16'hFFFF);
        chk16("sat_cnt_b", stall_cnt_w[1], 16'hFFFF);
        advance();
        settle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
